img_row_buf: RTL and testbench

Parametrised image row buffer for the COPROC image path. It holds ROWS rows of PIX_PER_ROW pixels and supports:
- per-pixel masked writes;
- an auto-incrementing streaming write pointer with an end-of-frame pulse;
- a registered read port with a valid flag;
- a background clear sequence.

It sits between the pixel fetch/DMA logic and the filter kernels, and generalises the fixed 512x640 single-port-style row buffer.

---
 rtl/img_row_buf.sv | 137 +++++++++++++
 tb/tb_img_row_buf.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/img_row_buf.sv
// Row buffer for the image path: masked row writes, streaming write pointer, registered reads
// and a background clear. Define IMG_BUF_BYPASS_EN for write-first read/write collisions.
module img_row_buf #(
  parameter int unsigned ROWS        = 512,
  parameter int unsigned PIX_PER_ROW = 80,
  parameter int unsigned PIX_BITS    = 8,
  parameter int unsigned AW          = $clog2(ROWS),
  parameter int unsigned DW          = PIX_PER_ROW * PIX_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic                   wr_auto,
  input  logic [AW-1:0]          waddr,
  input  logic [PIX_PER_ROW-1:0] wmask,
  input  logic [DW-1:0]          wdata,
  input  logic                   rd_en,
  input  logic [AW-1:0]          raddr,
  output logic [DW-1:0]          rdata,
  output logic                   rd_vld,
  input  logic                   clr,
  output logic                   busy,
  output logic [AW-1:0]          wptr,
  output logic                   frame_done
);

  localparam logic StIdle  = 1'b0;
  localparam logic StClear = 1'b1;
  localparam logic [AW-1:0] LastRow = AW'(ROWS - 1);

  logic          state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          frame_done_q, frame_done_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rd_vld_q;

  logic [DW-1:0] mem [ROWS];

  logic [AW-1:0] wr_row;
  logic          wr_ok;
  logic          clr_wr;
  logic          rd_ok;

  always_comb begin
    wr_row = wr_auto ? wptr_q : waddr;
    // Explicit addresses beyond the last row are dropped; the pointer is always in range.
    wr_ok  = (state_q == StIdle) && we && (wr_auto || (32'(waddr) < ROWS));
    clr_wr = (state_q == StClear);
    rd_ok  = 32'(raddr) < ROWS;
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    wptr_d       = wptr_q;
    frame_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (wr_ok && wr_auto) begin
          if (wptr_q == LastRow) begin
            wptr_d       = '0;
            frame_done_d = 1'b1;
          end else begin
            wptr_d = wptr_q + AW'(1);
          end
        end
        if (clr) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      default: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == LastRow) begin
          state_d   = StIdle;
          clr_cnt_d = '0;
          wptr_d    = '0;
        end
      end
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = rd_ok ? mem[raddr] : '0;
`ifdef IMG_BUF_BYPASS_EN
      if (clr_wr && (raddr == clr_cnt_q)) begin
        rdata_d = '0;
      end else if (wr_ok && rd_ok && (raddr == wr_row)) begin
        for (int i = 0; i < PIX_PER_ROW; i++) begin
          if (wmask[i]) rdata_d[i*PIX_BITS +: PIX_BITS] = wdata[i*PIX_BITS +: PIX_BITS];
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      clr_cnt_q    <= '0;
      wptr_q       <= '0;
      frame_done_q <= 1'b0;
      rdata_q      <= '0;
      rd_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      wptr_q       <= wptr_d;
      frame_done_q <= frame_done_d;
      rdata_q      <= rdata_d;
      rd_vld_q     <= rd_en;
    end
  end

  // Contents survive reset; a reset edge also suppresses that cycle's write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_wr) begin
        mem[clr_cnt_q] <= '0;
      end else if (wr_ok) begin
        for (int i = 0; i < PIX_PER_ROW; i++) begin
          if (wmask[i]) mem[wr_row][i*PIX_BITS +: PIX_BITS] <= wdata[i*PIX_BITS +: PIX_BITS];
        end
      end
    end
  end

  assign rdata      = rdata_q;
  assign rd_vld     = rd_vld_q;
  assign busy       = (state_q == StClear);
  assign wptr       = wptr_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_img_row_buf.sv
// Self-checking bench for img_row_buf: directed scenarios plus random traffic against a
// row-level reference model.
module tb_img_row_buf;

  localparam int unsigned ROWS = 6;
  localparam int unsigned PPR  = 80;
  localparam int unsigned PB   = 8;
  localparam int unsigned AW   = $clog2(ROWS);
  localparam int unsigned DW   = PPR * PB;

  logic           clk = 1'b0;
  logic           rst, we, wr_auto, rd_en, clr;
  logic [AW-1:0]  waddr, raddr;
  logic [PPR-1:0] wmask;
  logic [DW-1:0]  wdata;
  logic [DW-1:0]  rdata;
  logic           rd_vld, busy, frame_done;
  logic [AW-1:0]  wptr;

  img_row_buf #(
    .ROWS       (ROWS),
    .PIX_PER_ROW(PPR),
    .PIX_BITS   (PB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wr_auto   (wr_auto),
    .waddr     (waddr),
    .wmask     (wmask),
    .wdata     (wdata),
    .rd_en     (rd_en),
    .raddr     (raddr),
    .rdata     (rdata),
    .rd_vld    (rd_vld),
    .clr       (clr),
    .busy      (busy),
    .wptr      (wptr),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] m_mem [ROWS];
  logic [DW-1:0] m_rdata;
  logic          m_vld, m_fd, m_clearing;
  int            m_wptr, m_clr_row;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [7:0] v);
    return {PPR{v}};
  endfunction

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] model_read(input int row);
    return (row < int'(ROWS)) ? m_mem[row] : '0;
  endfunction

  // Apply the current inputs to the model, clock the DUT, then compare every output.
  task automatic tick();
    int row;
    if (rst) begin
      m_rdata = '0; m_vld = 1'b0; m_fd = 1'b0; m_clearing = 1'b0; m_wptr = 0;
    end else begin
`ifndef IMG_BUF_BYPASS_EN
      if (rd_en) m_rdata = model_read(int'(raddr));
`endif
      m_fd = 1'b0;
      if (m_clearing) begin
        m_mem[m_clr_row] = '0;
        m_clr_row++;
        if (m_clr_row == int'(ROWS)) begin
          m_clearing = 1'b0;
          m_wptr = 0;
        end
      end else begin
        if (we && (wr_auto || int'(waddr) < int'(ROWS))) begin
          row = wr_auto ? m_wptr : int'(waddr);
          for (int i = 0; i < int'(PPR); i++)
            if (wmask[i]) m_mem[row][i*PB +: PB] = wdata[i*PB +: PB];
          if (wr_auto) begin
            m_fd = (m_wptr == int'(ROWS) - 1);
            m_wptr = (m_wptr + 1) % int'(ROWS);
          end
        end
        if (clr) begin
          m_clearing = 1'b1;
          m_clr_row = 0;
        end
      end
`ifdef IMG_BUF_BYPASS_EN
      if (rd_en) begin
        if (m_clearing && m_clr_row > 0 && int'(raddr) == m_clr_row - 1) m_rdata = '0;
        else m_rdata = model_read(int'(raddr));
      end
`endif
      m_vld = rd_en;
    end
    @(posedge clk);
    #1;
    check("rdata", rdata, m_rdata);
    check("rd_vld", DW'(rd_vld), DW'(m_vld));
    check("busy", DW'(busy), DW'(m_clearing));
    check("wptr", DW'(wptr), DW'(m_wptr));
    check("frame_done", DW'(frame_done), DW'(m_fd));
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; rd_en = 1'b0; clr = 1'b0; wr_auto = 1'b0;
  endtask

  task automatic write_row(input int row, input logic [PPR-1:0] mask, input logic [DW-1:0] d);
    we = 1'b1; wr_auto = 1'b0; waddr = AW'(row); wmask = mask; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic read_row(input int row);
    rd_en = 1'b1; raddr = AW'(row);
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    idle();
    waddr = '0; raddr = '0; wmask = '0; wdata = '0;
    for (int r = 0; r < int'(ROWS); r++) m_mem[r] = 'x;
    m_clr_row = 0;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    idle();
    check("reset_rdata", rdata, '0);

    // Masked write
    write_row(5, '1, fill(8'hAA));
    write_row(5, PPR'(1), fill(8'h11));
    read_row(5);
    check("masked_row5", rdata, {{(PPR-1){8'hAA}}, 8'h11});
    check("masked_vld", DW'(rd_vld), DW'(1));
    tick();
    check("hold_vld_low", DW'(rd_vld), DW'(0));

    // Fill all rows, then random traffic
    for (int r = 0; r < int'(ROWS); r++) write_row(r, '1, rand_row());
    for (int c = 0; c < 400; c++) begin
      we      = ($urandom_range(2) != 0);
      wr_auto = $urandom_range(1) == 1;
      waddr   = AW'($urandom_range(7));
      wmask   = PPR'({$urandom, $urandom, $urandom});
      wdata   = rand_row();
      rd_en   = $urandom_range(1) == 1;
      raddr   = AW'($urandom_range(7));
      clr     = ($urandom_range(40) == 0);
      rst     = ($urandom_range(120) == 0);
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Streaming wrap: ROWS+1 pointer writes
    for (int k = 1; k <= int'(ROWS) + 1; k++) begin
      we = 1'b1; wr_auto = 1'b1; wmask = '1; wdata = fill(8'(k));
      tick();
      check("stream_wptr", DW'(wptr), DW'(k % int'(ROWS)));
      check("stream_fd", DW'(frame_done), DW'(k == int'(ROWS)));
    end
    idle();
    for (int r = 0; r < int'(ROWS); r++) begin
      read_row(r);
      check("stream_row", rdata, (r == 0) ? fill(8'(ROWS + 1)) : fill(8'(r + 1)));
    end

    // Clear with a dropped write mid-sequence
    for (int r = 0; r < int'(ROWS); r++) write_row(r, '1, fill(8'(r + 8'h40)));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    busy_cnt = busy ? 1 : 0;
    for (int c = 0; c < 20 && busy; c++) begin
      if (c == 2) begin
        we = 1'b1; waddr = AW'(5); wmask = '1; wdata = fill(8'h77);
      end
      tick();
      we = 1'b0;
      if (busy) busy_cnt++;
    end
    check("clear_busy_cycles", DW'(busy_cnt), DW'(ROWS));
    check("clear_wptr", DW'(wptr), '0);
    for (int r = 0; r < int'(ROWS); r++) begin
      read_row(r);
      check("clear_row", rdata, '0);
    end

    // Collision
    write_row(2, '1, fill(8'h33));
    we = 1'b1; wr_auto = 1'b0; waddr = AW'(2); wmask = '1; wdata = fill(8'h55);
    rd_en = 1'b1; raddr = AW'(2);
    tick();
    idle();
`ifdef IMG_BUF_BYPASS_EN
    check("collision", rdata, fill(8'h55));
`else
    check("collision", rdata, fill(8'h33));
`endif

    // Reset in the middle of a clear
    for (int r = 0; r < int'(ROWS); r++) write_row(r, '1, fill(8'hFF));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstclr_busy", DW'(busy), '0);
    check("rstclr_vld", DW'(rd_vld), '0);
    check("rstclr_rdata", rdata, '0);
    for (int r = 0; r < int'(ROWS); r++) begin
      read_row(r);
      check("rstclr_row", rdata, (r < 3) ? '0 : fill(8'hFF));
    end

    // Out-of-range write and read
    write_row(7, '1, fill(8'h99));
    for (int r = 0; r < int'(ROWS); r++) read_row(r);
    read_row(7);
    check("oor_rdata", rdata, '0);
    check("oor_vld", DW'(rd_vld), DW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
